// File: rtl/key_generator_pkg.sv
// Shared definitions for the key generator and key verifier: FSM encodings,
// Pearson table geometry and the table lookup helper.
package key_generator_pkg;

    localparam int PEARSON_TABLE_W = 2048;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HASH  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef logic [7:0] hash_t;

    // T[i] occupies bits [8*i+7 : 8*i] of the flattened table.
    function automatic hash_t table_entry(input logic [PEARSON_TABLE_W-1:0] tbl,
                                          input logic [7:0] idx);
        return tbl[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/key_generator_if.sv
// Request/response bundle between the wallet/account FSM and the key generator.
interface key_generator_if
    import key_generator_pkg::*;
#(
    parameter int KEY_W = 8
);
    logic                       start;
    logic [KEY_W-1:0]           seed;
    logic [PEARSON_TABLE_W-1:0] random_table;
    logic                       busy;
    logic                       done;
    logic [KEY_W-1:0]           private_key;
    logic [7:0]                 public_key;
    logic                       error;

    modport master (
        output start, seed, random_table,
        input  busy, done, private_key, public_key, error
    );

    modport slave (
        input  start, seed, random_table,
        output busy, done, private_key, public_key, error
    );
endinterface

// File: rtl/key_generator_pearson_lookup.sv
// One Pearson hash step, T[h ^ data]; shared with the verifier so both ends hash identically.
module pearson_lookup
    import key_generator_pkg::*;
(
    input  logic [PEARSON_TABLE_W-1:0] tbl,
    input  logic [7:0]                 h,
    input  logic [7:0]                 data,
    output logic [7:0]                 result
);
    assign result = table_entry(tbl, h ^ data);
endmodule

// File: rtl/key_generator.sv
// Issuer-side key generator: derives a private key from a seed and its non-zero
// 8-bit Pearson public key, regenerating the candidate through an LFSR on a zero hash.
module key_generator
    import key_generator_pkg::*;
#(
    parameter int                     KEY_BYTES = 1,
    parameter logic [8*KEY_BYTES-1:0] LFSR_TAPS = (8*KEY_BYTES)'(8'hB8),
    parameter int                     MAX_RETRY = 3
) (
    input  logic          clock,
    input  logic          reset,
    key_generator_if.slave kg
);
    localparam int         KEY_W    = 8 * KEY_BYTES;
    localparam int         RETRY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [7:0] LAST_IDX = 8'(KEY_BYTES - 1);

    logic [1:0]         state;
    logic [KEY_W-1:0]   key_reg;
    logic [7:0]         h;
    logic [7:0]         idx;
    logic [RETRY_W-1:0] retry;
    logic [7:0]         key_byte;
    logic [7:0]         h_next;
    logic [KEY_W-1:0]   private_key;
    logic [7:0]         public_key;
    logic               error;

    function automatic logic [KEY_W-1:0] lfsr_step(input logic [KEY_W-1:0] k);
        return (k >> 1) ^ (k[0] ? LFSR_TAPS : '0);
    endfunction

    // Byte 0 is the least significant byte of the candidate and is hashed first.
    always_comb begin
        key_byte = key_reg[7:0];
        for (int i = 0; i < KEY_BYTES; i++) begin
            if (idx == 8'(i)) key_byte = key_reg[8*i +: 8];
        end
    end

    pearson_lookup u_lookup (
        .tbl    (kg.random_table),
        .h      (h),
        .data   (key_byte),
        .result (h_next)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            key_reg     <= '0;
            h           <= '0;
            idx         <= '0;
            retry       <= '0;
            private_key <= '0;
            public_key  <= '0;
            error       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (kg.start) begin
                        // A zero seed would lock the LFSR at zero forever.
                        key_reg <= (kg.seed == '0) ? KEY_W'(1) : kg.seed;
                        h       <= '0;
                        idx     <= '0;
                        retry   <= '0;
                        error   <= 1'b0;
                        state   <= ST_HASH;
                    end
                end
                ST_HASH: begin
                    h   <= h_next;
                    idx <= idx + 8'd1;
                    if (idx == LAST_IDX) state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (h != 8'h00) begin
                        private_key <= key_reg;
                        public_key  <= h;
                        error       <= 1'b0;
                        state       <= ST_DONE;
                    end else if (retry == RETRY_W'(MAX_RETRY)) begin
                        private_key <= key_reg;
                        public_key  <= 8'h00;
                        error       <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        // Zero hash means "no key" to the verifier: try the next candidate.
                        key_reg <= lfsr_step(key_reg);
                        retry   <= retry + RETRY_W'(1);
                        h       <= '0;
                        idx     <= '0;
                        state   <= ST_HASH;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign kg.busy        = (state != ST_IDLE);
    assign kg.done        = (state == ST_DONE);
    assign kg.private_key = private_key;
    assign kg.public_key  = public_key;
    assign kg.error       = error;

endmodule

// File: tb/tb_key_generator.sv
// Randomized scoreboard bench for key_generator against a behavioural key/hash model.
module tb_key_generator;
    import key_generator_pkg::*;

    localparam int         KB   = 1;
    localparam int         KW   = 8 * KB;
    localparam logic [7:0] TAPS = 8'hB8;
    localparam int         MAXR = 3;

    typedef struct {
        logic [KW-1:0] priv;
        logic [7:0]    pub;
        logic          err;
        int            when;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    logic [7:0] tab[256];

    key_generator_if #(.KEY_W(KW)) kif ();

    key_generator #(.KEY_BYTES(KB), .LFSR_TAPS(TAPS), .MAX_RETRY(MAXR)) dut (
        .clock (clock),
        .reset (reset),
        .kg    (kif.slave)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] pearson(input logic [KW-1:0] key);
        logic [7:0] h;
        h = 8'h00;
        for (int b = 0; b < KB; b++) h = tab[h ^ key[8*b +: 8]];
        return h;
    endfunction

    // Expected result of a start accepted at clock edge e0.
    function automatic exp_t model(input logic [KW-1:0] seed, input int e0);
        logic [KW-1:0] key;
        logic [7:0]    h;
        exp_t          e;
        key = (seed == 0) ? KW'(1) : seed;
        e = '{priv: 0, pub: 0, err: 0, when: 0};
        for (int r = 0; r <= MAXR; r++) begin
            h = pearson(key);
            e.when = e0 + (KB + 1) * (r + 1);
            e.priv = key;
            if (h != 0) begin
                e.pub = h;
                e.err = 1'b0;
                return e;
            end
            if (r == MAXR) begin
                e.pub = 8'h00;
                e.err = 1'b1;
                return e;
            end
            key = (key >> 1) ^ (key[0] ? TAPS : 8'h00);
        end
        return e;
    endfunction

    task automatic load_table();
        for (int i = 0; i < 256; i++) kif.random_table[8*i +: 8] = tab[i];
    endtask

    task automatic wait_idle();
        int n = 0;
        while (kif.busy && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (kif.busy) check("idle_timeout", 32'(kif.busy), 32'd0);
    endtask

    task automatic issue(input logic [KW-1:0] s);
        wait_idle();
        load_table();
        kif.seed  = s;
        kif.start = 1'b1;
        sb.push_back(model(s, cyc + 1));
        @(negedge clock);
        kif.start = 1'b0;
        check("busy_after_start", 32'(kif.busy), 32'd1);
        wait_idle();
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (!reset && kif.done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(kif.done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("private_key", 32'(kif.private_key), 32'(e.priv));
                check("public_key", 32'(kif.public_key), 32'(e.pub));
                check("error", 32'(kif.error), 32'(e.err));
                check("done_cycle", 32'(cyc), 32'(e.when));
                if (!kif.error) check("loopback_hash", 32'(kif.public_key), 32'(pearson(kif.private_key)));
            end
        end
    end

    initial begin
        int t;
        int n;
        exp_t e;
        kif.start = 1'b0;
        kif.seed = '0;
        kif.random_table = '0;
        for (int i = 0; i < 256; i++) tab[i] = 8'(i);
        #12;
        check("reset_busy", 32'(kif.busy), 32'd0);
        check("reset_done", 32'(kif.done), 32'd0);
        check("reset_priv", 32'(kif.private_key), 32'd0);
        check("reset_pub", 32'(kif.public_key), 32'd0);
        check("reset_err", 32'(kif.error), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Directed cases with known answers.
        for (int i = 0; i < 256; i++) tab[i] = 8'(i);
        issue(8'h5A);
        check("ident_priv", 32'(kif.private_key), 32'h5A);
        check("ident_pub", 32'(kif.public_key), 32'h5A);
        issue(8'h00);
        check("zero_seed_priv", 32'(kif.private_key), 32'h01);
        check("zero_seed_pub", 32'(kif.public_key), 32'h01);
        for (int i = 0; i < 256; i++) tab[i] = 8'(i) ^ 8'h5A;
        issue(8'h5A);
        check("retry_priv", 32'(kif.private_key), 32'h2D);
        check("retry_pub", 32'(kif.public_key), 32'h77);
        for (int i = 0; i < 256; i++) tab[i] = 8'h00;
        issue(8'h11);
        check("exhaust_err", 32'(kif.error), 32'd1);
        check("exhaust_pub", 32'(kif.public_key), 32'h00);

        // Reset during HASH/CHECK abandons the run.
        for (int i = 0; i < 256; i++) tab[i] = 8'(i);
        issue(8'h33);
        load_table();
        kif.seed  = 8'h44;
        kif.start = 1'b1;
        sb.push_back(model(8'h44, cyc + 1));
        @(negedge clock);
        kif.start = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        void'(sb.pop_back());
        check("midrst_busy", 32'(kif.busy), 32'd0);
        check("midrst_done", 32'(kif.done), 32'd0);
        check("midrst_priv", 32'(kif.private_key), 32'd0);
        check("midrst_pub", 32'(kif.public_key), 32'd0);
        check("midrst_err", 32'(kif.error), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        issue(8'hC3);

        // start held for 10 cycles: accepted only when IDLE.
        for (int i = 0; i < 256; i++) tab[i] = 8'(i) ^ 8'h5A;
        load_table();
        kif.seed  = 8'h5A;
        kif.start = 1'b1;
        t = cyc + 1;
        n = 0;
        while (t <= cyc + 10) begin
            e = model(8'h5A, t);
            sb.push_back(e);
            t = e.when + 2;
            n++;
        end
        repeat (10) @(negedge clock);
        kif.start = 1'b0;
        wait_idle();

        // Randomized tables and seeds, often sparse to force retries and errors.
        for (int k = 0; k < 60; k++) begin
            int mode;
            mode = $urandom_range(0, 2);
            for (int i = 0; i < 256; i++) begin
                if (mode == 0) tab[i] = 8'($urandom);
                else tab[i] = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
            end
            issue(KW'($urandom));
        end

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("pending_expectations", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
